// File: rtl/mem_copy_engine_if.sv
// Data-memory bus used by mem_copy_engine.
// The master (the copy engine) drives the byte address, the write data and the
// write strobe. The slave (data memory, or the CPU/engine mux in front of it)
// returns read data combinationally from mem_addr and commits a write on
// posedge clk whenever mem_writeEnable is high.
//   mem_addr        master -> slave  byte address
//   mem_read        slave  -> master read data for mem_addr
//   mem_writeData   master -> slave  write data
//   mem_writeEnable master -> slave  write strobe
interface mem_copy_engine_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_read;
  logic [31:0]       mem_writeData;
  logic              mem_writeEnable;

  modport master (
    output mem_addr,
    output mem_writeData,
    output mem_writeEnable,
    input  mem_read
  );

  modport slave (
    input  mem_addr,
    input  mem_writeData,
    input  mem_writeEnable,
    output mem_read
  );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: moves blocks of 32-bit words through the data-memory port
// without CPU involvement. Two jobs are supported: forward copy (src -> dst,
// ascending, one READ cycle then one WRITE cycle per word) and constant fill
// (fill_data -> dst, one WRITE cycle per word). busy selects the engine on the
// external memory mux.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, fill         job request (honoured only in IDLE) and job type
//   src_addr, dst_addr  word-aligned byte addresses of the first words
//   count               number of words (0 completes immediately)
//   fill_data           word written by a fill job
//   busy, done, err     in-progress flag, completion pulse, rejected-start pulse
//   mem                 master side of the data-memory bus
module mem_copy_engine #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [31:0]       fill_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  mem_copy_engine_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              fill_mode;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [CNT_W-1:0]  remaining;
  logic [31:0]       fill_word;
  logic [31:0]       data_buf;
  logic              misaligned;

  // A source address only matters for copies; fills ignore src_addr entirely.
  assign misaligned = (dst_addr[1:0] != 2'b00) || (!fill && (src_addr[1:0] != 2'b00));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode. A rejected start stays in IDLE; the err pulse comes
  // from the datapath register below.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start && !misaligned) begin
          if (count == '0) begin
            state_next = DONE;
          end else if (fill) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ:  state_next = WRITE;
      WRITE: begin
        if (remaining == CNT_W'(1)) begin
          state_next = DONE;
        end else if (fill_mode) begin
          state_next = WRITE;
        end else begin
          state_next = READ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job registers. Arguments are latched only when IDLE accepts a start, so
  // starts seen while busy or in DONE leave the running job untouched.
  // Pointers wrap naturally modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_mode <= 1'b0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_word <= '0;
      data_buf  <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fill_mode <= fill;
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= count;
            fill_word <= fill_data;
            err       <= misaligned;
          end
        end
        READ: begin
          data_buf <= mem.mem_read;
        end
        WRITE: begin
          dst_ptr   <= dst_ptr + ADDR_W'(4);
          remaining <= remaining - CNT_W'(1);
          if (!fill_mode) begin
            src_ptr <= src_ptr + ADDR_W'(4);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode from registered state only. Reset also forces the strobe
  // low combinationally so that a reset arriving during a WRITE cycle
  // prevents that word from being committed by the memory at the same edge.
  always_comb begin
    busy                = 1'b0;
    done                = 1'b0;
    mem.mem_addr        = '0;
    mem.mem_writeData   = '0;
    mem.mem_writeEnable = 1'b0;
    if (!reset) begin
      case (state)
        READ: begin
          busy         = 1'b1;
          mem.mem_addr = src_ptr;
        end
        WRITE: begin
          busy                = 1'b1;
          mem.mem_addr        = dst_ptr;
          mem.mem_writeEnable = 1'b1;
          mem.mem_writeData   = fill_mode ? fill_word : data_buf;
        end
        DONE: begin
          done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine. Jobs are issued by applyStimulus,
// which runs a word-level reference model of copy/fill against a shadow
// memory and queues the expected writes, done and err pulses with the cycle
// in which each must appear. An independent monitor on the falling edge
// pops and compares whatever the engine presents.
module tb_mem_copy_engine;

  localparam int CNT_W  = 16;
  localparam int ADDR_W = 32;

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic              start     = 1'b0;
  logic              fill      = 1'b0;
  logic [ADDR_W-1:0] src_addr  = '0;
  logic [ADDR_W-1:0] dst_addr  = '0;
  logic [CNT_W-1:0]  count     = '0;
  logic [31:0]       fill_data = '0;
  logic              busy;
  logic              done;
  logic              err;

  mem_copy_engine_if #(.ADDR_W(ADDR_W)) bus ();

  mem_copy_engine #(
    .CNT_W (CNT_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .fill     (fill),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .count    (count),
    .fill_data(fill_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 256-word data memory; addresses alias modulo 1 KiB.
  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];

  function automatic logic [31:0] init_word(input int i);
    if (i < 3) return 32'(7 + i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  assign bus.mem_read = ram[bus.mem_addr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (bus.mem_writeEnable === 1'b1) ram[bus.mem_addr[9:2]] <= bus.mem_writeData;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  exp_err[$];
  int  busy_lo = 1;
  int  busy_hi = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic reportUnexpected(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: actual=pulse required=none (cycle %0d)", name, cyc);
  endtask

  // Called just after a rising edge; returns just after the rising edge that
  // brings cyc to target.
  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one job. Cycle k after the sampling edge is the period where
  // cyc == base + k. abort_after > 0 predicts only that many copy words and
  // no done pulse (the caller resets the engine mid-job).
  task automatic applyStimulus(input bit f, input logic [31:0] s, input logic [31:0] d,
                               input logic [15:0] n, input logic [31:0] fd,
                               input int abort_after, output int base, output int last);
    int          words;
    int          cnt;
    logic [31:0] a_s;
    logic [31:0] a_d;
    logic [31:0] w;
    bit          bad;
    base = cyc;
    cnt  = int'(n);
    bad  = (d[1:0] != 2'b00) || (!f && (s[1:0] != 2'b00));
    if (bad) begin
      exp_err.push_back(base + 1);
      last = base + 1;
    end else if (cnt == 0) begin
      exp_done.push_back(base + 1);
      last = base + 1;
    end else begin
      words = (abort_after > 0) ? abort_after : cnt;
      for (int i = 0; i < words; i++) begin
        a_s = s + 32'(4 * i);
        a_d = d + 32'(4 * i);
        w   = f ? fd : ref_mem[a_s[9:2]];
        ref_mem[a_d[9:2]] = w;
        exp_wr.push_back('{a_d, w, base + (f ? i + 1 : 2 * (i + 1))});
      end
      busy_lo = base + 1;
      if (abort_after > 0) begin
        busy_hi = base + 2 * abort_after + 1;
        last    = busy_hi;
      end else begin
        busy_hi = base + (f ? cnt : 2 * cnt);
        last    = busy_hi + 1;
        exp_done.push_back(last);
      end
    end
    start     = 1'b1;
    fill      = f;
    src_addr  = s;
    dst_addr  = d;
    count     = n;
    fill_data = fd;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic settle(input int last);
    wait_until(last + 2);
    checkOutput("pending_writes", 64'(exp_wr.size()), 64'd0);
    checkOutput("pending_done", 64'(exp_done.size()), 64'd0);
    checkOutput("pending_err", 64'(exp_err.size()), 64'd0);
    exp_wr.delete();
    exp_done.delete();
    exp_err.delete();
  endtask

  // Monitor: busy window, idle bus values, and every write/done/err event.
  wr_t mon_w;
  int  mon_c;
  bit  mon_busy;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      checkOutput("busy", 64'(busy), 64'(mon_busy));
      if (!mon_busy) begin
        checkOutput("idle_we", 64'(bus.mem_writeEnable), 64'd0);
        checkOutput("idle_addr", 64'(bus.mem_addr), 64'd0);
        checkOutput("idle_wdata", 64'(bus.mem_writeData), 64'd0);
      end
      if (bus.mem_writeEnable === 1'b1) begin
        if (exp_wr.size() == 0) begin
          reportUnexpected("unexpected_write");
        end else begin
          mon_w = exp_wr.pop_front();
          checkOutput("wr_addr", 64'(bus.mem_addr), 64'(mon_w.addr));
          checkOutput("wr_data", 64'(bus.mem_writeData), 64'(mon_w.data));
          checkOutput("wr_cycle", 64'(cyc), 64'(mon_w.cyc));
        end
      end
      if (done === 1'b1) begin
        if (exp_done.size() == 0) begin
          reportUnexpected("unexpected_done");
        end else begin
          mon_c = exp_done.pop_front();
          checkOutput("done_cycle", 64'(cyc), 64'(mon_c));
        end
      end
      if (err === 1'b1) begin
        if (exp_err.size() == 0) begin
          reportUnexpected("unexpected_err");
        end else begin
          mon_c = exp_err.pop_front();
          checkOutput("err_cycle", 64'(cyc), 64'(mon_c));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int          b;
  int          l;
  bit          rf;
  logic [31:0] rs;
  logic [31:0] rd;
  logic [15:0] rn;
  int          kind;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_we", 64'(bus.mem_writeEnable), 64'd0);
    checkOutput("rst_addr", 64'(bus.mem_addr), 64'd0);
    checkOutput("rst_wdata", 64'(bus.mem_writeData), 64'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    wait_until(cyc + 2);

    $display("[TB] directed copy of 3 words 0x0 -> 0x40");
    applyStimulus(1'b0, 32'h0, 32'h40, 16'd3, 32'h0, 0, b, l);
    settle(l);
    checkOutput("copy_w0", 64'(ram[16]), 64'd7);
    checkOutput("copy_w1", 64'(ram[17]), 64'd8);
    checkOutput("copy_w2", 64'(ram[18]), 64'd9);

    $display("[TB] directed fill of 4 words at 0x20");
    applyStimulus(1'b1, 32'h0, 32'h20, 16'd4, 32'hDEAD_BEEF, 0, b, l);
    settle(l);
    checkOutput("fill_w3", 64'(ram[11]), 64'hDEAD_BEEF);

    $display("[TB] zero count");
    applyStimulus(1'b0, 32'h80, 32'hC0, 16'd0, 32'h0, 0, b, l);
    settle(l);

    $display("[TB] misaligned starts");
    applyStimulus(1'b0, 32'h2, 32'h100, 16'd2, 32'h0, 0, b, l);
    settle(l);
    applyStimulus(1'b1, 32'h0, 32'h41, 16'd2, 32'h1111_2222, 0, b, l);
    settle(l);

    $display("[TB] reset during second write of a copy");
    applyStimulus(1'b0, 32'h100, 32'h140, 16'd3, 32'h0, 1, b, l);
    wait_until(b + 4);
    reset = 1'b1;
    wait_until(b + 5);
    reset = 1'b0;
    settle(b + 5);
    checkOutput("abort_w1_kept", 64'(ram[81]), 64'(init_word(81)));

    $display("[TB] ignored starts during copy and in DONE");
    applyStimulus(1'b0, 32'h180, 32'h1C0, 16'd3, 32'h0, 0, b, l);
    wait_until(b + 2);
    start = 1'b1; fill = 1'b1; dst_addr = 32'h200; count = 16'd5; fill_data = 32'h1234_5678;
    wait_until(b + 3);
    start = 1'b0;
    wait_until(b + 7);
    start = 1'b1;
    wait_until(b + 8);
    start = 1'b0;
    settle(l);

    $display("[TB] fill wrapping past the top of the address space");
    applyStimulus(1'b1, 32'h0, 32'hFFFF_FFFC, 16'd2, 32'hCAFE_F00D, 0, b, l);
    settle(l);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 24; j++) begin
      kind = int'($urandom_range(0, 9));
      rf   = 1'($urandom_range(0, 1));
      rs   = 32'($urandom_range(0, 191)) * 32'd4;
      rd   = 32'($urandom_range(0, 191)) * 32'd4;
      rn   = 16'($urandom_range(1, 16));
      if (kind == 0) begin
        if (rf || ($urandom_range(0, 1) == 1)) rd = rd | 32'($urandom_range(1, 3));
        else rs = rs | 32'($urandom_range(1, 3));
      end else if (kind == 1) begin
        rn = 16'd0;
      end
      applyStimulus(rf, rs, rd, rn, $urandom, 0, b, l);
      settle(l);
    end

    for (int i = 0; i < 256; i++) checkOutput($sformatf("ram[%0d]", i), 64'(ram[i]), 64'(ref_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
